// File: rtl/inert_poll_pkg.sv
// +----------------------------------------------------------------------------+
// | inert_pkg : states, register map and command helpers for the IMU poller    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package inert_pkg;

  typedef enum logic [3:0] {
    SETTLE = 4'd0,
    ID_RD  = 4'd1,
    ID_WT  = 4'd2,
    CFG_WR = 4'd3,
    CFG_WT = 4'd4,
    IDLE   = 4'd5,
    RD     = 4'd6,
    RD_WT  = 4'd7,
    PUB    = 4'd8,
    ERR    = 4'd9
  } state_t;

  localparam logic [6:0] WHO_AM_I    = 7'h0F;
  localparam logic [6:0] INT_CFG     = 7'h0D;
  localparam logic [6:0] DATA_BASE   = 7'h22;
  localparam logic [7:0] WHO_VAL     = 8'h6A;
  localparam logic [7:0] INT_CFG_VAL = 8'h02;
  localparam logic [3:0] LAST_IDX    = 4'd11;

  function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
    return {1'b1, addr, 8'h00};
  endfunction

  function automatic logic [15:0] wr_cmd(input logic [6:0] addr, input logic [7:0] data);
    return {1'b0, addr, data};
  endfunction

endpackage

`default_nettype wire

// File: rtl/inert_poll_int_sync.sv
// +----------------------------------------------------------------------------+
// | int_sync : two-flop synchronizer with rising-edge detect for async pins    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

`default_nettype wire

// File: rtl/inert_poll.sv
// +----------------------------------------------------------------------------+
// | inert_poll : iNEMO settle/ID/config sequencer and INT-driven 12-byte poller |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module inert_poll
  import inert_pkg::*;
#(
  parameter int SETTLE_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               INT,
  output logic               wrt,
  output logic [15:0]        wt_data,
  input  logic               done,
  input  logic [15:0]        rd_data,
  output logic signed [15:0] ptch,
  output logic signed [15:0] roll,
  output logic signed [15:0] yaw,
  output logic signed [15:0] ax,
  output logic signed [15:0] ay,
  output logic signed [15:0] az,
  output logic               vld,
  output logic               rdy,
  output logic               id_err
);

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [3:0]          idx;
  logic                pend;
  logic [7:0]          shadow [12];
  logic                int_rise;
  logic                unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:8];

  int_sync u_int_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (INT),
    .rise     (int_rise)
  );

  // Command states are entered with wrt/wt_data already registered, so each
  // command state lasts exactly one cycle before its wait state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      idx        <= '0;
      pend       <= 1'b0;
      wrt        <= 1'b0;
      wt_data    <= '0;
      vld        <= 1'b0;
      rdy        <= 1'b0;
      id_err     <= 1'b0;
      ptch       <= '0;
      roll       <= '0;
      yaw        <= '0;
      ax         <= '0;
      ay         <= '0;
      az         <= '0;
      for (int i = 0; i < 12; i++) shadow[i] <= '0;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      if (int_rise && rdy && (state != IDLE)) pend <= 1'b1;

      case (state)
        SETTLE: begin
          if (settle_cnt == '1) begin
            state   <= ID_RD;
            wrt     <= 1'b1;
            wt_data <= rd_cmd(WHO_AM_I);
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ID_RD: state <= ID_WT;
        ID_WT: begin
          if (done) begin
            if (rd_data[7:0] == WHO_VAL) begin
              state   <= CFG_WR;
              wrt     <= 1'b1;
              wt_data <= wr_cmd(INT_CFG, INT_CFG_VAL);
            end else begin
              id_err <= 1'b1;
              state  <= ERR;
            end
          end
        end
        CFG_WR: state <= CFG_WT;
        CFG_WT: begin
          if (done) begin
            rdy   <= 1'b1;
            state <= IDLE;
          end
        end
        // PUB hands a pending burst straight to RD so it starts right after vld
        IDLE, PUB: begin
          if (int_rise || pend) begin
            pend    <= 1'b0;
            idx     <= '0;
            state   <= RD;
            wrt     <= 1'b1;
            wt_data <= rd_cmd(DATA_BASE);
          end else begin
            state <= IDLE;
          end
        end
        RD: state <= RD_WT;
        RD_WT: begin
          if (done) begin
            shadow[idx] <= rd_data[7:0];
            if (idx == LAST_IDX) begin
              ptch  <= {shadow[1],  shadow[0]};
              roll  <= {shadow[3],  shadow[2]};
              yaw   <= {shadow[5],  shadow[4]};
              ax    <= {shadow[7],  shadow[6]};
              ay    <= {shadow[9],  shadow[8]};
              az    <= {rd_data[7:0], shadow[10]};
              vld   <= 1'b1;
              state <= PUB;
            end else begin
              idx     <= idx + 4'd1;
              state   <= RD;
              wrt     <= 1'b1;
              wt_data <= rd_cmd(DATA_BASE + {3'b000, idx + 4'd1});
            end
          end
        end
        ERR:     state <= ERR;
        default: state <= SETTLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inert_poll.sv
// +----------------------------------------------------------------------------+
// | tb_inert_poll : SPI stub + IMU byte model bench for inert_poll             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_inert_poll;

  localparam int SW = 4;

  typedef struct packed {
    logic [95:0] bytes;   // byte i at [8i+7:8i], i = address - 0x22
    logic [95:0] words;   // {ptch, roll, yaw, ax, ay, az}
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               INT = 1'b0;
  logic               done = 1'b0;
  logic [15:0]        rd_data = 16'h0000;
  logic               wrt;
  logic [15:0]        wt_data;
  logic signed [15:0] ptch, roll, yaw, ax, ay, az;
  logic               vld, rdy, id_err;
  logic [95:0]        outs;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  imu [12];
  logic [7:0]  id_val = 8'h6A;
  logic [15:0] cmds [$];
  int          wrt_cnt = 0;
  int          unstable = 0;
  logic [95:0] prev_outs = '0;

  bit          busy = 1'b0;
  int          lat_cnt = 0;
  logic [15:0] cur_cmd = 16'h0;
  logic [31:0] rnd;

  vec_t vecs [3];

  assign outs = {ptch, roll, yaw, ax, ay, az};

  inert_poll #(.SETTLE_W(SW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .INT     (INT),
    .wrt     (wrt),
    .wt_data (wt_data),
    .done    (done),
    .rd_data (rd_data),
    .ptch    (ptch),
    .roll    (roll),
    .yaw     (yaw),
    .ax      (ax),
    .ay      (ay),
    .az      (az),
    .vld     (vld),
    .rdy     (rdy),
    .id_err  (id_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] response(input logic [15:0] c);
    int a;
    a = int'(c[14:8]);
    if (!c[15]) return 8'h00;
    if (a == 15) return id_val;
    if (a >= 34 && a <= 45) return imu[a-34];
    return 8'h00;
  endfunction

  // Little-endian byte pairs, six words in output order.
  function automatic logic [95:0] model_words();
    logic [95:0] res;
    int w;
    res = '0;
    for (int k = 0; k < 6; k++) begin
      w = int'(imu[2*k]) + 256 * int'(imu[2*k+1]);
      res = {res[79:0], w[15:0]};
    end
    return res;
  endfunction

  // SPI_mnrch stand-in: answers each wrt with a done 1..4 cycles later.
  initial begin : spi_stub
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (busy) begin
        if (lat_cnt == 0) begin
          rnd = $urandom;
          rd_data = {rnd[7:0], response(cur_cmd)};
          done = 1'b1;
          busy = 1'b0;
          check("wt_hold", wt_data, cur_cmd);
        end else begin
          lat_cnt--;
        end
      end else if (wrt) begin
        cur_cmd = wt_data;
        cmds.push_back(cur_cmd);
        busy = 1'b1;
        lat_cnt = $urandom_range(0, 3);
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && wrt) wrt_cnt++;
      if (rst_n && !vld && (outs !== prev_outs)) unstable++;
      prev_outs = outs;
    end
  end

  // Called just after a negedge with rst_n low; releases reset and times the settle.
  task automatic do_settle(input string tag, input bit pulse_int);
    int n;
    cmds.delete();
    #2 rst_n = 1'b1;
    n = 0;
    while (!wrt && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (pulse_int && n == 3) INT = 1'b1;
      if (pulse_int && n == 8) INT = 1'b0;
    end
    check({tag, "_settle_cycles"}, n, 16);
    check({tag, "_first_cmd"}, wt_data, 16'h8F00);
  endtask

  task automatic wait_rdy(input string tag);
    int m;
    m = 0;
    while (!rdy && m < 200) begin @(negedge clk); m++; end
    check({tag, "_rdy"}, rdy, 1);
  endtask

  task automatic run_burst(input logic [95:0] exp, input string tag);
    int n, m, errs;
    cmds.delete();
    @(posedge clk); #1 INT = 1'b1;
    n = 0;
    while (!wrt && n < 50) begin @(posedge clk); #1; n++; end
    check({tag, "_int_lat"}, n, 3);
    INT = 1'b0;
    m = 0;
    do begin @(negedge clk); m++; end while (!vld && m < 1000);
    check({tag, "_vld"}, vld, 1);
    check({tag, "_outs"}, outs, exp);
    check({tag, "_ncmd"}, cmds.size(), 12);
    errs = 0;
    for (int i = 0; i < cmds.size(); i++)
      if (cmds[i] !== 16'h8000 + 16'((34 + i) * 256)) errs++;
    check({tag, "_cmd_seq"}, errs, 0);
    @(negedge clk);
    check({tag, "_vld_pulse"}, vld, 0);
  endtask

  initial begin : main
    logic [95:0] exp;
    int m, hold, base;
    bit fired;

    vecs[0].bytes = 96'h0C0B0A09_08070605_04030201;
    vecs[0].words = 96'h0201_0403_0605_0807_0A09_0C0B;
    vecs[1].bytes = 96'hFFFF0000_ABCD1234_7FFF8000;
    vecs[1].words = 96'h8000_7FFF_1234_ABCD_0000_FFFF;
    vecs[2].bytes = 96'h1B1A1918_17161514_13121110;
    vecs[2].words = 96'h1110_1312_1514_1716_1918_1B1A;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", outs, 96'h0);
    check("reset_ctl", {wrt, vld, rdy, id_err, wt_data}, 20'h0);

    // Power-up, with an INT edge during settle that must be ignored
    do_settle("boot", 1'b1);
    wait_rdy("boot");
    repeat (30) @(negedge clk);
    check("cfg_ncmd", cmds.size(), 2);
    check("cfg_id_cmd", cmds[0], 16'h8F00);
    check("cfg_wr_cmd", cmds[1], 16'h0D02);

    foreach (vecs[v]) begin
      for (int i = 0; i < 12; i++) imu[i] = vecs[v].bytes[8*i +: 8];
      run_burst(vecs[v].words, $sformatf("vec%0d", v));
      repeat (5) @(negedge clk);
    end

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 12; i++) begin rnd = $urandom; imu[i] = rnd[7:0]; end
      run_burst(model_words(), $sformatf("rand%0d", r));
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end

    // INT edge mid-burst queues exactly one follow-on burst
    for (int i = 0; i < 12; i++) begin rnd = $urandom; imu[i] = rnd[7:0]; end
    exp = model_words();
    cmds.delete();
    @(posedge clk); #1 INT = 1'b1;
    repeat (3) @(posedge clk);
    #1 INT = 1'b0;
    fired = 1'b0; hold = 0; m = 0;
    do begin
      @(negedge clk); m++;
      if (hold > 0) begin
        hold--;
        if (hold == 0) INT = 1'b0;
      end else if (!fired && cmds.size() >= 6) begin
        INT = 1'b1; fired = 1'b1; hold = 3;
      end
    end while (!vld && m < 1000);
    check("pend_vld1", vld, 1);
    check("pend_outs1", outs, exp);
    for (int i = 0; i < 12; i++) begin rnd = $urandom; imu[i] = rnd[7:0]; end
    exp = model_words();
    @(posedge clk); #1;
    check("pend_start", wrt, 1);
    m = 0;
    do begin @(negedge clk); m++; end while (!vld && m < 1000);
    check("pend_vld2", vld, 1);
    check("pend_outs2", outs, exp);
    check("pend_ncmd", cmds.size(), 24);
    repeat (40) @(negedge clk);
    check("pend_single", cmds.size(), 24);

    // Reset during byte 7 of a burst
    for (int i = 0; i < 12; i++) begin rnd = $urandom; imu[i] = rnd[7:0]; end
    cmds.delete();
    @(posedge clk); #1 INT = 1'b1;
    repeat (3) @(posedge clk);
    #1 INT = 1'b0;
    m = 0;
    while (cmds.size() < 8 && m < 1000) begin @(negedge clk); m++; end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", outs, 96'h0);
    check("midrst_ctl", {wrt, vld, rdy, id_err, wt_data}, 20'h0);
    repeat (10) @(negedge clk);
    do_settle("midrst", 1'b0);
    wait_rdy("midrst");
    repeat (5) @(negedge clk);
    for (int i = 0; i < 12; i++) begin rnd = $urandom; imu[i] = rnd[7:0]; end
    run_burst(model_words(), "post_rst");

    // WHO_AM_I mismatch locks the sequencer
    @(negedge clk);
    #2 rst_n = 1'b0;
    id_val = 8'h00;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    m = 0;
    while (!id_err && m < 200) begin @(negedge clk); m++; end
    check("idbad_err", id_err, 1);
    check("idbad_rdy", rdy, 0);
    base = wrt_cnt;
    INT = 1'b1;
    repeat (4) @(negedge clk);
    INT = 1'b0;
    repeat (1000) @(negedge clk);
    check("idbad_no_wrt", wrt_cnt - base, 0);
    check("idbad_err_sticky", id_err, 1);

    check("outs_stable", unstable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inert_poll.md
# inert_poll

IMU polling sequencer between `SPI_mnrch` (downstream) and the navigation/fusion logic (upstream consumer of its outputs). After power-up it waits out a settle time, checks the iNEMO WHO_AM_I register, and enables the data-ready interrupt. It then answers each INT by reading all 12 inertial data bytes over `SPI_mnrch` and presenting six 16-bit signed readings atomically with a one-cycle valid strobe.

## Interface
- `SETTLE_W`, default 16: settle timer width; the first SPI command is issued 2^SETTLE_W cycles after reset release.
- `clk` in 1: system clock, the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `INT` in 1: iNEMO data-ready, asynchronous to `clk`.
- `wrt` out 1: one-cycle start strobe to `SPI_mnrch`.
- `wt_data` out 16: SPI command word, `{R/W, addr[6:0], data[7:0]}`.
- `done` in 1: transaction complete from `SPI_mnrch`.
- `rd_data` in 16: response; only `[7:0]` is used, valid while `done` is high.
- `ptch`, `roll`, `yaw`, `ax`, `ay`, `az` out 16 each, signed: latest readings.
- `vld` out 1: one-cycle pulse when all six outputs have just updated.
- `rdy` out 1: configuration complete, sticky.
- `id_err` out 1: WHO_AM_I mismatch, sticky until reset.

## Operation
- Command formats:
  - Read command: `{1'b1, addr[6:0], 8'h00}`.
  - Write command: `{1'b0, addr[6:0], data}`.
- States:
  - SETTLE: timer counts to all-ones, then go to ID_RD.
  - ID_RD: issue read of 0x0F.
  - ID_WT: on `done`, if `rd_data[7:0]==8'h6A` go to CFG_WR; otherwise set `id_err` and go to ERR.
  - CFG_WR: issue write 0x0D=0x02.
  - CFG_WT: on `done`, set `rdy` and go to IDLE.
  - IDLE: on a synchronized INT rising edge, or with `pend` set, clear `pend`, set idx=0, go to RD.
  - RD: issue read of address 0x22+idx.
  - RD_WT: on `done`, store `rd_data[7:0]` in shadow byte idx. If idx==11 go to PUB; else idx++ and go to RD.
  - PUB: copy shadow to outputs, pulse `vld`, go to IDLE.
  - ERR: terminal; no further `wrt` until reset.
- Byte map, low byte at the even address:
  - 0x22/0x23 → `ptch`
  - 0x24/0x25 → `roll`
  - 0x26/0x27 → `yaw`
  - 0x28/0x29 → `ax`
  - 0x2A/0x2B → `ay`
  - 0x2C/0x2D → `az`
- INT handling:
  - INT is double-flopped, then edge-detected.
  - A rising edge seen outside IDLE after `rdy` sets `pend`. Multiple edges collapse into one pending burst.
  - Edges before `rdy` are ignored.
- Outputs never change except in PUB, so all six update in the same cycle.
- idx is 4 bits; values 12–15 are unreachable.

## Timing
- Reset values: `wrt`=0, `wt_data`=0, all six data outputs=0, `vld`=0, `rdy`=0, `id_err`=0, state=SETTLE, `pend`=0, synchronizer flops=0.
- `wrt` is high for exactly one cycle, on the cycle of entry into a command state.
- `wt_data` is registered and valid from the `wrt` cycle until `done`.
- The next `wrt` comes no earlier than 1 cycle after the `done` cycle.
- `done` is sampled only in wait states; a `done` seen elsewhere is ignored.
- INT-to-first-`wrt` latency from IDLE: 3 cycles (2 sync stages + edge register). A pending burst starts 1 cycle after `vld`.
- `vld` is asserted the cycle after the 12th `done`.
- Reset asserted mid-transaction clears everything immediately (asynchronously) and restarts at SETTLE. The in-flight `SPI_mnrch` transfer is abandoned, since `SPI_mnrch` shares the same reset.

## Structure
- Package `inert_pkg`, shared with the fusion block:
  - state enum
  - address constants `WHO_AM_I=7'h0F`, `INT_CFG=7'h0D`, `DATA_BASE=7'h22`
  - constants `WHO_VAL=8'h6A`, `INT_CFG_VAL=8'h02`
- Sub-module `int_sync`: 2-flop synchronizer plus rising-edge detect, reset to 0. It is reusable for other asynchronous pins.
- Top-level contents: FSM, settle counter, idx counter, a 12×8 shadow register, and output registers.

## Test plan
- Test setup: `SETTLE_W`=4, with `SPI_mnrch` and `SPI_iNEMO1` attached, `inert_data.hex` loaded as `imu_data`.
- **Settle:** release reset → `wrt` stays 0 for 16 cycles, then the first `wt_data`=16'h8F00.
- **Config:** WHO_AM_I returns 0x6A → next command is 16'h0D02. After its `done`, `rdy`=1 and `iNEMO.NEMO_setup`=1.
- **Burst:** first INT → 12 commands 16'hA200…16'hAD00 in order, then one `vld` pulse. Outputs match `imu_data[0]`: `ptch`=[47:32], `roll`=[31:16], `yaw`=[15:0], `ax`=[95:80], `ay`=[79:64], `az`=[63:48]. Repeat for all 64 entries.
- **ID mismatch:** a stub returns `rd_data`=16'h0000 for the ID read → `id_err`=1, `rdy`=0, and no `wrt` is seen for 1000 cycles.
- **Pending INT:** force an INT edge at byte 5 of a burst → the next burst's first `wrt` occurs 1 cycle after `vld`. All outputs are constant between `vld` pulses.
- **Mid-burst reset:** assert `rst_n`=0 during byte 7 → all outputs read 0 in the same cycle. After release, the sequence restarts with 16'h8F00 following the settle time.
